// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: video and CPU request ports, the shared RAM port
// and the statistics outputs. master = arbiter side, slave = requesters/RAM side.
interface vram_arbiter_if;
   logic        vid_req_i;
   logic [15:0] vid_addr_i;
   logic        vid_ack_o;
   logic        vid_valid_o;
   logic [7:0]  vid_data_o;

   logic        cpu_req_i;
   logic        cpu_we_i;
   logic [15:0] cpu_addr_i;
   logic [7:0]  cpu_din_i;
   logic        cpu_ack_o;
   logic        cpu_valid_o;
   logic [7:0]  cpu_dout_o;

   logic        ram_en_o;
   logic        ram_we_o;
   logic [15:0] ram_addr_o;
   logic [7:0]  ram_din_o;
   logic [7:0]  ram_dout_i;

   logic [15:0] stat_conflicts_o;
   logic [15:0] stat_forced_o;

   modport master (
      input  vid_req_i, vid_addr_i,
      output vid_ack_o, vid_valid_o, vid_data_o,
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_din_i,
      output cpu_ack_o, cpu_valid_o, cpu_dout_o,
      output ram_en_o, ram_we_o, ram_addr_o, ram_din_o,
      input  ram_dout_i,
      output stat_conflicts_o, stat_forced_o
   );

   modport slave (
      output vid_req_i, vid_addr_i,
      input  vid_ack_o, vid_valid_o, vid_data_o,
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_din_i,
      input  cpu_ack_o, cpu_valid_o, cpu_dout_o,
      input  ram_en_o, ram_we_o, ram_addr_o, ram_din_o,
      output ram_dout_i,
      input  stat_conflicts_o, stat_forced_o
   );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port video-RAM arbiter: video wins conflicts by default, a wait counter
// forces a CPU grant after CPU_MAX_WAIT lost conflicts. Macro VRAM_ARB_STATS_EN adds counters.
module vram_arbiter #(
   parameter int CPU_MAX_WAIT = 4,
   parameter int WAIT_W       = 4
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   vram_arbiter_if.master bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_VID  = 2'd1;
   localparam logic [1:0] ST_CPU  = 2'd2;

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(CPU_MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};

   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_d;

   logic              vid_elig_s;
   logic              cpu_elig_s;
   logic              conflict_s;
   logic              cpu_turn_s;
   logic              cpu_wr_s;
   logic              rd_grant_s;

   logic              ram_en_q;
   logic              ram_we_q;
   logic [15:0]       ram_addr_q;
   logic [15:0]       ram_addr_d;
   logic [7:0]        ram_din_q;
   logic [7:0]        ram_din_d;

   logic              tag1_vld_q;
   logic              tag1_cpu_q;
   logic              tag2_vld_q;
   logic              tag2_cpu_q;

   logic              vid_valid_q;
   logic [7:0]        vid_data_q;
   logic              cpu_valid_q;
   logic [7:0]        cpu_dout_q;

   // An ACK high this cycle masks the same requester, so a held REQ is not re-granted.
   always_comb begin
      vid_elig_s = bus.vid_req_i && (state_q != ST_VID);
      cpu_elig_s = bus.cpu_req_i && (state_q != ST_CPU);
      conflict_s = vid_elig_s && cpu_elig_s;
      cpu_turn_s = (wait_q >= WAIT_LIMIT);
      state_d    = ST_IDLE;
      if (conflict_s) begin
         state_d = cpu_turn_s ? ST_CPU : ST_VID;
      end else if (vid_elig_s) begin
         state_d = ST_VID;
      end else if (cpu_elig_s) begin
         state_d = ST_CPU;
      end else begin
         state_d = ST_IDLE;
      end
   end

   always_comb begin
      wait_d = wait_q;
      if (state_d == ST_CPU) begin
         wait_d = {WAIT_W{1'b0}};
      end else if (conflict_s && (wait_q != WAIT_SAT)) begin
         wait_d = wait_q + WAIT_W'(1);
      end else begin
         wait_d = wait_q;
      end
   end

   always_comb begin
      cpu_wr_s   = (state_d == ST_CPU) && bus.cpu_we_i;
      rd_grant_s = (state_d != ST_IDLE) && !cpu_wr_s;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      case (state_d)
         ST_VID: begin
            ram_addr_d = bus.vid_addr_i;
         end
         ST_CPU: begin
            ram_addr_d = bus.cpu_addr_i;
            if (bus.cpu_we_i) begin
               ram_din_d = bus.cpu_din_i;
            end else begin
               ram_din_d = ram_din_q;
            end
         end
         default: begin
            ram_addr_d = ram_addr_q;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         wait_q  <= {WAIT_W{1'b0}};
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ram_en_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= 16'h0000;
         ram_din_q  <= 8'h00;
      end else begin
         ram_en_q   <= (state_d != ST_IDLE);
         ram_we_q   <= cpu_wr_s;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
      end
   end

   // Tag stage 1 lines up with the RAM_EN cycle, stage 2 with the RAM data cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tag1_vld_q <= 1'b0;
         tag1_cpu_q <= 1'b0;
         tag2_vld_q <= 1'b0;
         tag2_cpu_q <= 1'b0;
      end else begin
         tag1_vld_q <= rd_grant_s;
         tag1_cpu_q <= (state_d == ST_CPU);
         tag2_vld_q <= tag1_vld_q;
         tag2_cpu_q <= tag1_cpu_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vid_valid_q <= 1'b0;
         vid_data_q  <= 8'h00;
         cpu_valid_q <= 1'b0;
         cpu_dout_q  <= 8'h00;
      end else begin
         vid_valid_q <= tag2_vld_q && !tag2_cpu_q;
         cpu_valid_q <= tag2_vld_q && tag2_cpu_q;
         if (tag2_vld_q && !tag2_cpu_q) begin
            vid_data_q <= bus.ram_dout_i;
         end else begin
            vid_data_q <= vid_data_q;
         end
         if (tag2_vld_q && tag2_cpu_q) begin
            cpu_dout_q <= bus.ram_dout_i;
         end else begin
            cpu_dout_q <= cpu_dout_q;
         end
      end
   end

`ifdef VRAM_ARB_STATS_EN
   logic [15:0] stat_conf_q;
   logic [15:0] stat_forced_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stat_conf_q   <= 16'h0000;
         stat_forced_q <= 16'h0000;
      end else begin
         if (conflict_s && (stat_conf_q != 16'hFFFF)) begin
            stat_conf_q <= stat_conf_q + 16'd1;
         end else begin
            stat_conf_q <= stat_conf_q;
         end
         if (conflict_s && cpu_turn_s && (stat_forced_q != 16'hFFFF)) begin
            stat_forced_q <= stat_forced_q + 16'd1;
         end else begin
            stat_forced_q <= stat_forced_q;
         end
      end
   end

   assign bus.stat_conflicts_o = stat_conf_q;
   assign bus.stat_forced_o    = stat_forced_q;
`else
   assign bus.stat_conflicts_o = 16'h0000;
   assign bus.stat_forced_o    = 16'h0000;
`endif

   assign bus.vid_ack_o   = (state_q == ST_VID);
   assign bus.cpu_ack_o   = (state_q == ST_CPU);
   assign bus.ram_en_o    = ram_en_q;
   assign bus.ram_we_o    = ram_we_q;
   assign bus.ram_addr_o  = ram_addr_q;
   assign bus.ram_din_o   = ram_din_q;
   assign bus.vid_valid_o = vid_valid_q;
   assign bus.vid_data_o  = vid_data_q;
   assign bus.cpu_valid_o = cpu_valid_q;
   assign bus.cpu_dout_o  = cpu_dout_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed test-plan steps plus random traffic, checked
// against a transaction-level model (grant owner, wait count, read-return queue).
module tb_vram_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   vram_arbiter_if b ();
   vram_arbiter_if z ();

   vram_arbiter #(.CPU_MAX_WAIT(4), .WAIT_W(4)) dut  (.clk_i(clk), .rst_n_i(rst_n), .bus(b));
   vram_arbiter #(.CPU_MAX_WAIT(0), .WAIT_W(4)) dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(z));

   localparam int MAXW = 4;

   function automatic logic [7:0] init_byte(input logic [15:0] a);
      return (a == 16'h9000) ? 8'hA5 : (a[7:0] ^ a[15:8]);
   endfunction

   // Synchronous single-port RAM, one-cycle read latency.
   logic [7:0] ram_mem [0:65535];
   bit         ram_wr  [0:65535];
   logic [7:0] ram_q = 8'h00;
   always @(posedge clk) begin
      if (b.ram_en_o) begin
         if (b.ram_we_o) begin
            ram_mem[b.ram_addr_o] <= b.ram_din_o;
            ram_wr[b.ram_addr_o]  <= 1'b1;
         end else begin
            ram_q <= ram_wr[b.ram_addr_o] ? ram_mem[b.ram_addr_o] : init_byte(b.ram_addr_o);
         end
      end
   end
   assign b.ram_dout_i = ram_q;
   assign z.ram_dout_i = 8'h00;

   typedef struct {
      int         due;
      bit         cpu;
      logic [7:0] data;
   } rd_t;

   logic [7:0]  ref_mem [0:65535];
   rd_t         rdq [$];
   int          m_owner, m_wait, m_conf, m_forced, cyc;
   logic        m_we;
   logic [15:0] m_addr;
   logic [7:0]  m_din, m_vdata, m_cdata;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic chk_stats();
`ifdef VRAM_ARB_STATS_EN
      chk("stat_conflicts", b.stat_conflicts_o, m_conf);
      chk("stat_forced", b.stat_forced_o, m_forced);
`else
      chk("stat_conflicts", b.stat_conflicts_o, 32'd0);
      chk("stat_forced", b.stat_forced_o, 32'd0);
`endif
   endtask

   // One clock cycle: drive inputs, check this cycle's outputs, advance the model.
   task automatic step(input logic vr, input logic [15:0] va, input logic cr, input logic cw,
                       input logic [15:0] ca, input logic [7:0] cd);
      bit v_el, c_el, conf, e_vv, e_cv;
      int g;
      b.vid_req_i  = vr;
      b.vid_addr_i = va;
      b.cpu_req_i  = cr;
      b.cpu_we_i   = cw;
      b.cpu_addr_i = ca;
      b.cpu_din_i  = cd;
      v_el = vr && (m_owner != 1);
      c_el = cr && (m_owner != 2);
      conf = v_el && c_el;
      if (conf)      g = (m_wait >= MAXW) ? 2 : 1;
      else if (v_el) g = 1;
      else if (c_el) g = 2;
      else           g = 0;
      @(negedge clk);
      e_vv = 1'b0;
      e_cv = 1'b0;
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
         if (rdq[0].cpu) begin e_cv = 1'b1; m_cdata = rdq[0].data; end
         else            begin e_vv = 1'b1; m_vdata = rdq[0].data; end
         void'(rdq.pop_front());
      end
      chk("vid_ack", b.vid_ack_o, m_owner == 1);
      chk("cpu_ack", b.cpu_ack_o, m_owner == 2);
      chk("ram_en", b.ram_en_o, m_owner != 0);
      chk("ram_we", b.ram_we_o, (m_owner == 2) && m_we);
      if (m_owner != 0) chk("ram_addr", b.ram_addr_o, m_addr);
      chk("ram_din", b.ram_din_o, m_din);
      chk("vid_valid", b.vid_valid_o, e_vv);
      chk("vid_data", b.vid_data_o, m_vdata);
      chk("cpu_valid", b.cpu_valid_o, e_cv);
      chk("cpu_dout", b.cpu_dout_o, m_cdata);
      chk_stats();
      if (conf) begin
         if (m_conf < 65535) m_conf++;
         if (g == 2 && m_forced < 65535) m_forced++;
      end
      if (g == 2)    m_wait = 0;
      else if (conf) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
      m_owner = g;
      if (g == 1) begin
         m_addr = va;
         m_we   = 1'b0;
         rdq.push_back('{due: cyc + 3, cpu: 1'b0, data: ref_mem[va]});
      end else if (g == 2) begin
         m_addr = ca;
         m_we   = cw;
         if (cw) begin
            m_din       = cd;
            ref_mem[ca] = cd;
         end else begin
            rdq.push_back('{due: cyc + 3, cpu: 1'b1, data: ref_mem[ca]});
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      {b.vid_req_i, b.cpu_req_i, b.cpu_we_i} = 3'b000;
      {z.vid_req_i, z.cpu_req_i, z.cpu_we_i} = 3'b000;
      z.vid_addr_i = 16'h0000; z.cpu_addr_i = 16'h0000; z.cpu_din_i = 8'h00;
      m_owner = 0; m_wait = 0; m_conf = 0; m_forced = 0;
      m_we = 1'b0; m_addr = 16'h0000; m_din = 8'h00; m_vdata = 8'h00; m_cdata = 8'h00;
      rdq.delete();
      @(negedge clk);
      chk("rst_main_outs", {b.vid_ack_o, b.cpu_ack_o, b.ram_en_o, b.ram_we_o,
                            b.vid_valid_o, b.cpu_valid_o}, 32'd0);
      chk("rst_main_bus", {b.ram_addr_o, b.ram_din_o, b.vid_data_o}, 32'd0);
      chk("rst_main_dout", b.cpu_dout_o, 32'd0);
      chk("rst_main_stats", {b.stat_conflicts_o, b.stat_forced_o}, 32'd0);
      chk("rst_dut0_outs", {z.vid_ack_o, z.cpu_ack_o, z.ram_en_o, z.ram_we_o,
                            z.vid_valid_o, z.cpu_valid_o}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bit          vpend, cpend, ack_v, ack_c, cw;
      logic [15:0] va, ca;
      logic [7:0]  cd;
      rst_n = 1'b0;
      cyc   = 0;
      for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
      do_reset();

      // Video-only read of 0x9000 returning 0xA5.
      step(1'b1, 16'h9000, 1'b0, 1'b0, 16'h0000, 8'h00);
      chk("tp_vid_ack", b.vid_ack_o, 32'd1);
      chk("tp_vid_addr", b.ram_addr_o, 32'h9000);
      step(1'b1, 16'h9000, 1'b0, 1'b0, 16'h0000, 8'h00);
      idle();
      chk("tp_vid_valid", b.vid_valid_o, 32'd1);
      chk("tp_vid_data", b.vid_data_o, 32'hA5);
      idle();

      // CPU write of 0x3C to 0x9123.
      step(1'b0, 16'h0000, 1'b1, 1'b1, 16'h9123, 8'h3C);
      chk("tp_wr_port", {b.ram_en_o, b.ram_we_o, b.cpu_ack_o}, 32'b111);
      chk("tp_wr_addr", b.ram_addr_o, 32'h9123);
      chk("tp_wr_din", b.ram_din_o, 32'h3C);
      step(1'b0, 16'h0000, 1'b1, 1'b1, 16'h9123, 8'h3C);
      chk("tp_wr_once", {b.ram_en_o, b.ram_we_o, b.cpu_ack_o}, 32'b000);
      idle(); idle();

      // CPU_MAX_WAIT=0 instance: simultaneous requests, CPU first then video.
      z.vid_req_i = 1'b1; z.vid_addr_i = 16'h1111;
      z.cpu_req_i = 1'b1; z.cpu_addr_i = 16'h2222; z.cpu_we_i = 1'b0;
      idle();
      chk("mw0_first_cpu", {z.cpu_ack_o, z.vid_ack_o}, 32'b10);
      chk("mw0_first_addr", z.ram_addr_o, 32'h2222);
      idle();
      z.cpu_req_i = 1'b0;
      chk("mw0_then_vid", {z.cpu_ack_o, z.vid_ack_o}, 32'b01);
      chk("mw0_then_addr", z.ram_addr_o, 32'h1111);
      idle();
      z.vid_req_i = 1'b0;
      chk("mw0_done", {z.cpu_ack_o, z.vid_ack_o}, 32'b00);
      idle();

      // Reset between a read's grant and its return.
      step(1'b1, 16'h4321, 1'b0, 1'b0, 16'h0000, 8'h00);
      do_reset();
      for (int i = 0; i < 5; i++) idle();
      chk("rst_no_valid", {b.vid_valid_o, b.vid_data_o}, 32'd0);

      // Ten isolated conflicts: video wins four, CPU the fifth, repeated.
      do_reset();
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 16'($urandom), 1'b1, 1'($urandom), 16'($urandom), 8'($urandom));
         idle();
      end
`ifdef VRAM_ARB_STATS_EN
      chk("tp_stat_conf", b.stat_conflicts_o, 32'd10);
      chk("tp_stat_forced", b.stat_forced_o, 32'd2);
`else
      chk("tp_stat_conf", b.stat_conflicts_o, 32'd0);
      chk("tp_stat_forced", b.stat_forced_o, 32'd0);
`endif
      idle(); idle();

      // Random protocol-compliant requesters (REQ held until ACK).
      vpend = 1'b0; cpend = 1'b0;
      va = 16'h0000; ca = 16'h0000; cw = 1'b0; cd = 8'h00;
      for (int i = 0; i < 400; i++) begin
         ack_v = (m_owner == 1);
         ack_c = (m_owner == 2);
         if (!vpend && $urandom_range(0, 1) == 1) begin
            vpend = 1'b1;
            va    = 16'($urandom_range(0, 63)) + 16'h8000;
         end
         if (!cpend && $urandom_range(0, 2) == 0) begin
            cpend = 1'b1;
            ca    = 16'($urandom_range(0, 63)) + 16'h8000;
            cw    = 1'($urandom);
            cd    = 8'($urandom);
         end
         step(vpend, va, cpend, cw, ca, cd);
         if (ack_v) vpend = 1'b0;
         if (ack_c) cpend = 1'b0;
      end

      // Random unconstrained requests: builds up the wait counter and forced grants.
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 31)) + 16'h8000,
              1'($urandom), 1'($urandom), 16'($urandom_range(0, 31)) + 16'h8000, 8'($urandom));
      end
      for (int i = 0; i < 4; i++) idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
